// File: rtl/ring_decoder_checker.sv
// -----------------------------------------------------------------------------
// ring_decoder_checker
//
// Receive-side monitor for a one-hot ring counter. Each enabled sample of
// ring_in is checked for one-hot legality, decoded to a binary index and
// compared against the rotate-left successor of the previous legal sample.
// A small SEARCH/ACQ/LOCKED machine declares lock after LOCK_COUNT
// consecutive in-sequence legal samples. While locked, sequence breaks and
// illegal samples are counted in a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   en         sample enable; ring_in is evaluated only when en=1
//   clr_err    synchronous clear of err_count (wins over a same-edge error)
//   ring_in    ring vector under test
//   index      binary position of the set bit in the last legal sample
//   valid      last sample was one-hot
//   locked     sequence lock achieved
//   step_err   1-cycle pulse: legal but out-of-sequence sample while locked
//   illegal    1-cycle pulse: sample was not one-hot
//   err_count  saturating count of errors taken while locked
// All outputs are registered (1-cycle latency from the sampling edge).
// -----------------------------------------------------------------------------
module ring_decoder_checker #(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 4,
    parameter  int ERR_CNT_W  = 8,
    localparam int IDX_W      = $clog2(WIDTH),
    localparam int RUN_W      = $clog2(LOCK_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clr_err,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IDX_W-1:0]     index,
    output logic                 valid,
    output logic                 locked,
    output logic                 step_err,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [RUN_W-1:0]     run_reg, run_next;
    logic [WIDTH-1:0]     prev_reg, prev_next;
    logic [IDX_W-1:0]     index_reg, index_next;
    logic                 valid_reg, valid_next;
    logic                 step_err_reg, step_err_next;
    logic                 illegal_reg, illegal_next;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    logic                 is_legal;
    logic                 in_seq;
    logic                 err_hit;
    logic [WIDTH-1:0]     expected;
    logic [IDX_W-1:0]     decoded;
    logic [IDX_W-1:0]     idx_terms [WIDTH];

    // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
    assign is_legal = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
    assign expected = {prev_reg[WIDTH-2:0], prev_reg[WIDTH-1]};
    assign in_seq   = is_legal && (ring_in == expected);

    // Encoder: each bit contributes its own position; OR-ing the terms gives
    // the index whenever the input is one-hot (only used in that case).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
        assign idx_terms[gi] = ring_in[gi] ? IDX_W'(gi) : '0;
    end

    always_comb begin
        decoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            decoded = decoded | idx_terms[i];
        end
    end

    // State / data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= SEARCH;
            run_reg       <= '0;
            prev_reg      <= '0;
            index_reg     <= '0;
            valid_reg     <= 1'b0;
            step_err_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            prev_reg      <= prev_next;
            index_reg     <= index_next;
            valid_reg     <= valid_next;
            step_err_reg  <= step_err_next;
            illegal_reg   <= illegal_next;
            err_count_reg <= err_count_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        run_next      = run_reg;
        prev_next     = prev_reg;
        index_next    = index_reg;
        valid_next    = valid_reg;
        step_err_next = 1'b0;
        illegal_next  = 1'b0;
        err_hit       = 1'b0;

        if (en) begin
            if (is_legal) begin
                index_next = decoded;
                valid_next = 1'b1;
                prev_next  = ring_in;
                unique case (state_reg)
                    SEARCH: begin
                        run_next   = RUN_W'(1);
                        state_next = (LOCK_COUNT == 1) ? LOCKED : ACQ;
                    end
                    ACQ: begin
                        if (in_seq) begin
                            if (int'(run_reg) + 1 >= LOCK_COUNT) begin
                                run_next   = RUN_W'(LOCK_COUNT);
                                state_next = LOCKED;
                            end else begin
                                run_next = run_reg + RUN_W'(1);
                            end
                        end else begin
                            // Out-of-sequence sample restarts the run from itself.
                            run_next = RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            step_err_next = 1'b1;
                            err_hit       = 1'b1;
                            run_next      = RUN_W'(1);
                            state_next    = ACQ;
                        end
                    end
                    default: begin
                        run_next   = '0;
                        state_next = SEARCH;
                    end
                endcase
            end else begin
                // Not one-hot: index and prev hold, lock is lost.
                valid_next   = 1'b0;
                illegal_next = 1'b1;
                err_hit      = (state_reg == LOCKED);
                run_next     = '0;
                state_next   = SEARCH;
            end
        end

        if (clr_err) begin
            err_count_next = '0;
        end else if (err_hit && (err_count_reg != '1)) begin
            err_count_next = err_count_reg + ERR_CNT_W'(1);
        end else begin
            err_count_next = err_count_reg;
        end
    end

    // Outputs, all taken straight from registers.
    always_comb begin
        index     = index_reg;
        valid     = valid_reg;
        locked    = (state_reg == LOCKED);
        step_err  = step_err_reg;
        illegal   = illegal_reg;
        err_count = err_count_reg;
    end

endmodule

// File: tb/tb_ring_decoder_checker.sv
module tb_ring_decoder_checker;

    localparam int W   = 4;
    localparam int L   = 4;
    localparam int ECW = 2;
    localparam int MAXC = (1 << ECW) - 1;

    logic           clk;
    logic           reset_n;
    logic           en;
    logic           clr_err;
    logic [W-1:0]   ring_in;
    logic [1:0]     index;
    logic           valid;
    logic           locked;
    logic           step_err;
    logic           illegal;
    logic [ECW-1:0] err_count;

    int n_total;
    int n_pass;

    // Reference model, kept in terms of ring positions.
    int m_idx, m_valid, m_locked, m_step, m_ill, m_cnt, m_run, m_prev;

    ring_decoder_checker #(.WIDTH(W), .LOCK_COUNT(L), .ERR_CNT_W(ECW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .clr_err   (clr_err),
        .ring_in   (ring_in),
        .index     (index),
        .valid     (valid),
        .locked    (locked),
        .step_err  (step_err),
        .illegal   (illegal),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] oh(input int pos);
        logic [W-1:0] v;
        v = '0;
        v[pos % W] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_valid = 0; m_locked = 0; m_step = 0; m_ill = 0;
        m_cnt = 0; m_run = 0; m_prev = -1;
    endtask

    task automatic model_step(input bit e, input bit c, input logic [W-1:0] r);
        int pos;
        bit hit;
        bit insq;
        hit = 0;
        m_step = 0;
        m_ill = 0;
        if (e) begin
            if ($countones(r) == 1) begin
                pos = 0;
                for (int i = 0; i < W; i++) if (r[i]) pos = i;
                insq = (m_prev >= 0) && (pos == (m_prev + 1) % W);
                if (m_locked != 0) begin
                    if (!insq) begin
                        m_step = 1; hit = 1; m_locked = 0; m_run = 1;
                    end
                end else if (m_run == 0) begin
                    m_run = 1;
                    if (L == 1) m_locked = 1;
                end else if (insq) begin
                    m_run++;
                    if (m_run >= L) m_locked = 1;
                end else begin
                    m_run = 1;
                end
                m_idx = pos; m_valid = 1; m_prev = pos;
            end else begin
                m_valid = 0; m_ill = 1;
                if (m_locked != 0) hit = 1;
                m_locked = 0; m_run = 0;
            end
        end
        if (c) m_cnt = 0;
        else if (hit && m_cnt < MAXC) m_cnt++;
    endtask

    task automatic step(input bit e, input bit c, input logic [W-1:0] r);
        en = e; clr_err = c; ring_in = r;
        @(posedge clk);
        model_step(e, c, r);
        #1;
        $display("t=%0t en=%0b clr=%0b ring=%b -> idx=%0d v=%0b lk=%0b se=%0b il=%0b cnt=%0d",
                 $time, e, c, r, index, valid, locked, step_err, illegal, err_count);
        chk("index", int'(index), m_idx);
        chk("valid", int'(valid), m_valid);
        chk("locked", int'(locked), m_locked);
        chk("step_err", int'(step_err), m_step);
        chk("illegal", int'(illegal), m_ill);
        chk("err_count", int'(err_count), m_cnt);
    endtask

    task automatic relock();
        for (int k = 0; k < 12; k++) begin
            if (m_locked != 0) break;
            step(1, 0, oh((m_prev < 0) ? 0 : m_prev + 1));
        end
    endtask

    initial begin
        int exp_sat [5];
        int sel;
        exp_sat = '{1, 2, 3, 3, 3};
        n_total = 0;
        n_pass = 0;
        model_reset();
        reset_n = 1'b0; en = 1'b0; clr_err = 1'b0; ring_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_index", int'(index), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_count", int'(err_count), 0);
        reset_n = 1'b1;

        // 1: acquire lock, then wrap 1000 -> 0001.
        step(1, 0, 4'b0001);
        step(1, 0, 4'b0010);
        step(1, 0, 4'b0100);
        step(1, 0, 4'b1000);
        chk("lock_after_4", int'(locked), 1);
        step(1, 0, 4'b0001);
        chk("wrap_index", int'(index), 0);
        chk("wrap_locked", int'(locked), 1);

        // 2: sequence break while locked, then relock.
        step(1, 0, 4'b0100);
        chk("break_step_err", int'(step_err), 1);
        chk("break_index", int'(index), 2);
        step(1, 0, 4'b1000);
        step(1, 0, 4'b0001);
        step(1, 0, 4'b0010);
        chk("relock", int'(locked), 1);

        // 3: illegal samples while locked and then in SEARCH.
        step(1, 0, 4'b0000);
        chk("illegal_index_hold", int'(index), 1);
        step(1, 0, 4'b0110);

        // 4: lock parked at 0010, en low with noise, then continue.
        step(0, 1, 4'b0000);
        relock();
        for (int k = 0; k < 8 && m_prev != 1; k++) step(1, 0, oh(m_prev + 1));
        for (int k = 0; k < 3; k++) step(0, 0, W'($urandom));
        step(1, 0, 4'b0100);
        chk("hold_locked", int'(locked), 1);
        chk("hold_index", int'(index), 2);

        // 5: saturation of a 2-bit counter, then clear beating an error.
        step(0, 1, 4'b0000);
        relock();
        for (int k = 0; k < 5; k++) begin
            step(1, 0, oh(m_prev + 2));
            chk("sat_seq", int'(err_count), exp_sat[k]);
            relock();
        end
        step(1, 1, oh(m_prev + 2));
        chk("clr_wins", int'(err_count), 0);

        // Randomized traffic, mostly legal rotations.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60)      step(1, ($urandom_range(0, 19) == 0), oh((m_prev < 0) ? 0 : m_prev + 1));
            else if (sel < 75) step(1, 0, oh($urandom_range(0, W - 1)));
            else if (sel < 85) step(1, 0, W'($urandom));
            else               step(0, ($urandom_range(0, 9) == 0), W'($urandom));
        end

        // 6: asynchronous reset while locked.
        step(0, 1, 4'b0000);
        relock();
        reset_n = 1'b0;
        #2;
        chk("async_index", int'(index), 0);
        chk("async_valid", int'(valid), 0);
        chk("async_locked", int'(locked), 0);
        chk("async_step_err", int'(step_err), 0);
        chk("async_illegal", int'(illegal), 0);
        chk("async_err_count", int'(err_count), 0);
        model_reset();
        #2;
        reset_n = 1'b1;
        step(1, 0, 4'b0001);
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_locked", int'(locked), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
